// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice sequenced LSB first.
// Optional subtract mode via SERIAL_ADD_SUB_EN (adds sub port).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             sub_in, sub_q;
    logic             load;
    logic             a0, b0, hs, s_bit, c_next;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_d;
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    // Two half adders plus the carry flop form the shared slice
    assign a0     = a_q[0];
    assign b0     = b_q[0] ^ sub_q;
    assign hs     = a0 ^ b0;
    assign s_bit  = hs ^ c_q;
    assign c_next = (a0 & b0) | (c_q & hs);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        load    = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                load    = start;
            end
            RUN: begin
                acc_d = {s_bit, acc_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = {s_bit, acc_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            c_d     = sub_in;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
`ifdef SERIAL_ADD_SUB_EN
            sub_d   = sub_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // {carry_out, sum} expected from plain arithmetic
    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic s);
        logic [W-1:0] d;
        if (s) begin
            d = x - y;
            return {(x >= y), d};
        end
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Issue one op from a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bcnt,
                          output logic [W:0] res, output logic held);
        logic [W:0] prev;
        prev  = {carry_out, sum};
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        held  = 1'b1;
        res   = '0;
        for (int k = 0; k <= 3 * W; k++) begin
            if (done === 1'b1) begin
                lat = k;
                res = {carry_out, sum};
                break;
            end
            if (busy === 1'b1) bcnt++;
            if ({carry_out, sum} !== prev) held = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, carry_out, sum} !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0",
                     {busy, done, carry_out, sum});
        end
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, carry_out, sum} !== '0) begin
            failures++;
            $display("FAIL reset_hold got=%h want=0",
                     {busy, done, carry_out, sum});
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bcnt, d0;
        logic [W:0] res;
        logic held;
        d0 = done_cnt;
        run_op(8'h5A, 8'h3C, lat, bcnt, res, held);
        checks++;
        if (res !== model(8'h5A, 8'h3C, 1'b0)) begin
            failures++;
            $display("FAIL basic_sum got=%h want=%h", res,
                     model(8'h5A, 8'h3C, 1'b0));
        end
        checks++;
        if (lat !== W) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=%0d", lat, W);
        end
        checks++;
        if (bcnt !== W) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d want=%0d", bcnt, W);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00 || done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL basic_done_pulse done=%b busy=%b n=%0d want 0 0 1",
                     done, busy, done_cnt - d0);
        end
    endtask

    task automatic test_carry_hold();
        int lat, bcnt;
        logic [W:0] res;
        logic held;
        run_op(8'hFF, 8'h01, lat, bcnt, res, held);
        checks++;
        if (res !== 9'h100) begin
            failures++;
            $display("FAIL carry_sum got=%h want=100", res);
        end
        checks++;
        if (held !== 1'b1 || lat !== W) begin
            failures++;
            $display("FAIL carry_hold held=%b lat=%0d want 1 %0d",
                     held, lat, W);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int d0, n;
        d0 = done_cnt;
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n <= 3 * W; n++) begin
            if (n == 3) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h01;
            end
            if (n == 4) start = 1'b0;
            if (done === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if ({carry_out, sum} !== 9'h030 || n !== W) begin
            failures++;
            $display("FAIL ignore_result got=%h lat=%0d want=030 %0d",
                     {carry_out, sum}, n, W);
        end
        repeat (W + 2) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_second_done n=%0d busy=%b want 1 0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int d0, lat, bcnt;
        logic [W:0] res;
        logic held;
        start = 1'b1;
        a = 8'h77;
        b = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, carry_out, sum} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%h want=0",
                     {busy, done, carry_out, sum});
        end
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0 || sum !== '0) begin
            failures++;
            $display("FAIL midrun_no_done n=%0d busy=%b sum=%h want 0 0 0",
                     done_cnt - d0, busy, sum);
        end
        run_op(8'hC3, 8'h5E, lat, bcnt, res, held);
        checks++;
        if (res !== model(8'hC3, 8'h5E, 1'b0) || lat !== W) begin
            failures++;
            $display("FAIL midrun_recover got=%h lat=%0d want=%h %0d",
                     res, lat, model(8'hC3, 8'h5E, 1'b0), W);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic [W:0] res;
        logic held;
        run_op(8'h5A, 8'h3C, lat, bcnt, res, held);
        checks++;
        if (res !== 9'h096) begin
            failures++;
            $display("FAIL b2b_first got=%h want=096", res);
        end
        run_op(8'h80, 8'h80, lat, bcnt, res, held);
        checks++;
        if (res !== 9'h100 || lat !== W || bcnt !== W) begin
            failures++;
            $display("FAIL b2b_second got=%h lat=%0d busy=%0d want=100 %0d %0d",
                     res, lat, bcnt, W, W);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_random();
        int lat, bcnt, gap;
        logic [W:0] res, exp;
        logic held;
        logic [W-1:0] x, y;
        for (int i = 0; i < 25; i++) begin
            x = W'($urandom);
            y = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub = 1'($urandom);
`endif
            exp = model(x, y, sub);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run_op(x, y, lat, bcnt, res, held);
            checks++;
            if (res !== exp || lat !== W) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h sub=%b got=%h lat=%0d want=%h %0d",
                         i, x, y, sub, res, lat, exp, W);
            end
        end
        sub = 1'b0;
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int lat, bcnt;
        logic [W:0] res;
        logic held;
        sub = 1'b1;
        run_op(8'h10, 8'h01, lat, bcnt, res, held);
        checks++;
        if (res !== 9'h10F) begin
            failures++;
            $display("FAIL sub_no_borrow got=%h want=10f", res);
        end
        run_op(8'h01, 8'h02, lat, bcnt, res, held);
        checks++;
        if (res !== 9'h0FF) begin
            failures++;
            $display("FAIL sub_borrow got=%h want=0ff", res);
        end
        sub = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_hold();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
